// File: rtl/fs_serial.sv
// ============================================================================
// Module      : fs_serial
// Description : Digit-serial full subtractor. Computes a - b - bin over WIDTH
//               bits, DIGIT bits per clock, least-significant digit first.
//               The inter-digit borrow is held in a flop. A start/busy/done
//               handshake wraps each operation; borrow-out, signed overflow
//               and zero flags accompany the difference.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               start  - request, accepted only while busy==0
//               a, b   - minuend / subtrahend (sampled on accepting edge)
//               bin    - borrow-in (sampled on accepting edge)
//               busy   - high while digits are being processed
//               done   - one-cycle pulse, results valid from this cycle
//               d      - difference (a - b - bin) mod 2^WIDTH
//               bo     - borrow-out (unsigned a < b + bin)
//               ov     - two's-complement overflow of a - b - bin
//               zero   - d == 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             ov,
    output logic             zero
);

    localparam int c_NDIG = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int c_CW   = (c_NDIG > 1) ? $clog2(c_NDIG) : 1;

    // Elaboration-time guard against unusable parameter combinations.
    if (WIDTH < 1 || DIGIT < 1) begin : g_bad_range
        $error("fs_serial: WIDTH and DIGIT must both be >= 1");
    end else if ((WIDTH % DIGIT) != 0) begin : g_bad_divide
        $error("fs_serial: DIGIT must divide WIDTH exactly");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;
    logic              w_finish;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_borrow;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_res;

    logic              r_done;
    logic [WIDTH-1:0]  r_d;
    logic              r_bo;
    logic              r_ov;
    logic              r_zero;

    logic [DIGIT:0]        w_sub;
    logic [DIGIT-1:0]      w_diff;
    logic                  w_bout;
    logic [WIDTH+DIGIT-1:0] w_cat;
    logic [WIDTH-1:0]      w_res_next;
    logic                  w_ov;

    // ------------------------------------------------------------------
    // Digit subtractor: the extra top bit of the (DIGIT+1)-bit difference
    // goes high exactly when the digit result went negative, i.e. borrow.
    // ------------------------------------------------------------------
    assign w_sub  = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                  - (DIGIT+1)'(r_borrow);
    assign w_diff = w_sub[DIGIT-1:0];
    assign w_bout = w_sub[DIGIT];

    // New digit enters at the MSB end; after NDIG shifts the first digit
    // has reached bit 0. The concatenation also covers DIGIT == WIDTH.
    assign w_cat      = {w_diff, r_res};
    assign w_res_next = w_cat[WIDTH+DIGIT-1:DIGIT];

    // Borrow into the MSB is recovered from the MSB sum bit
    // (d_msb = a_msb ^ b_msb ^ borrow_in); overflow is borrow-in XOR
    // borrow-out at that bit. Only meaningful on the final digit, where
    // r_a/r_b[DIGIT-1] hold the original operand MSBs.
    assign w_ov   = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_diff[DIGIT-1] ^ w_bout;

    assign w_last = (r_cnt == c_CW'(c_NDIG - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
            r_res    <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> DIGIT;
            r_b      <= r_b >> DIGIT;
            r_borrow <= w_bout;
            r_res    <= w_res_next;
            r_cnt    <= r_cnt + c_CW'(1);
        end
    end

    // Result outputs only update on completion, so partial results are
    // never visible while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_d    <= '0;
            r_bo   <= 1'b0;
            r_ov   <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_d    <= w_res_next;
                r_bo   <= w_bout;
                r_ov   <= w_ov;
                r_zero <= (w_res_next == '0);
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = r_done;
    assign d    = r_d;
    assign bo   = r_bo;
    assign ov   = r_ov;
    assign zero = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_fs_serial.sv
// ============================================================================
// Module      : tb_fs_serial
// Description : Self-checking bench for fs_serial. A 16-bit/4-bit instance
//               runs a table of directed vectors plus handshake and abort
//               sequences; 4-bit instances with DIGIT=1 and DIGIT=4 are swept
//               exhaustively against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fs_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // 16-bit, 4-bit digit instance
    logic        start16;
    logic [15:0] a16, b16;
    logic        bin16;
    logic        busy16, done16, bo16, ov16, zero16;
    logic [15:0] d16;

    // 4-bit instances share stimulus
    logic        start4;
    logic [3:0]  a4, b4;
    logic        bin4;
    logic        busy41, done41, bo41, ov41, zero41;
    logic [3:0]  d41;
    logic        busy44, done44, bo44, ov44, zero44;
    logic [3:0]  d44;

    fs_serial #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .d(d16), .bo(bo16), .ov(ov16), .zero(zero16)
    );

    fs_serial #(.WIDTH(4), .DIGIT(1)) u_dut41 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy41), .done(done41), .d(d41), .bo(bo41), .ov(ov41), .zero(zero41)
    );

    fs_serial #(.WIDTH(4), .DIGIT(4)) u_dut44 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy44), .done(done44), .d(d44), .bo(bo44), .ov(ov44), .zero(zero44)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected {d, bo, ov, zero} currently held by the 16-bit instance.
    logic [18:0] prev16 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive a request and return #1 after the accepting edge. Inputs are
    // then scrambled to show they are not needed after acceptance.
    task automatic launch16(input logic [15:0] av, input logic [15:0] bv, input logic binv);
        a16     = av;
        b16     = bv;
        bin16   = binv;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        a16     = ~av;
        b16     = ~bv;
        bin16   = ~binv;
        chk("busy_after_accept", {30'd0, busy16, done16}, 32'h2);
    endtask

    // Wait the remaining n edges of an operation; outputs must hold the
    // previous result while busy, then show the new one with done.
    task automatic wait16(input string tag, input int n, input logic [15:0] ed,
                          input logic ebo, input logic eov, input logic ezero);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (k < n) begin
                chk({tag, "_running"}, {11'd0, busy16, done16, d16, bo16, ov16, zero16},
                    {11'd0, 2'b10, prev16});
            end else begin
                chk({tag, "_done"}, {11'd0, busy16, done16, d16, bo16, ov16, zero16},
                    {11'd0, 2'b01, ed, ebo, eov, ezero});
            end
        end
        prev16 = {ed, ebo, eov, ezero};
    endtask

    function automatic logic [6:0] model4(input int av, input int bv, input int binv);
        int r, sa, sb, sr;
        logic [3:0] dd;
        r  = av - bv - binv;
        sa = (av > 7) ? av - 16 : av;
        sb = (bv > 7) ? bv - 16 : bv;
        sr = sa - sb - binv;
        dd = r[3:0];
        return {dd, (r < 0), ((sr < -8) || (sr > 7)), (dd == 4'd0)};
    endfunction

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        zero;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [6:0] exp4;
        logic [6:0] prev41;

        vt[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vt[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[6] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0};
        vt[7] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1};

        // Reset with start held high: nothing may start.
        start16 = 1'b1; a16 = 16'h0005; b16 = 16'h0003; bin16 = 1'b0;
        start4  = 1'b0; a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("reset_state", {11'd0, busy16, done16, d16, bo16, ov16, zero16}, 32'd0);
        end
        start16 = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", {30'd0, busy16, done16}, 32'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            launch16(vt[i].a, vt[i].b, vt[i].bin);
            wait16($sformatf("vec%0d", i), 4, vt[i].d, vt[i].bo, vt[i].ov, vt[i].zero);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_pulse", i), {30'd0, busy16, done16}, 32'd0);
        end

        // Start pulsed while busy is ignored; start in the done cycle is taken.
        launch16(16'h0005, 16'h0003, 1'b0);
        @(posedge clk);
        #1;
        a16 = 16'hAAAA; b16 = 16'h1111; bin16 = 1'b1; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        chk("ignored_start_busy", {30'd0, busy16, done16}, 32'h2);
        wait16("hs_first", 2, 16'h0002, 1'b0, 1'b0, 1'b0);
        launch16(16'h0010, 16'h0001, 1'b0);
        wait16("hs_b2b", 4, 16'h000F, 1'b0, 1'b0, 1'b0);

        // Abort: reset during cycle 2 of an operation.
        launch16(16'h1111, 16'h0101, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {11'd0, busy16, done16, d16, bo16, ov16, zero16}, 32'd0);
        prev16 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", {11'd0, busy16, done16, d16, bo16, ov16, zero16}, 32'd0);
        end
        launch16(16'h00FF, 16'h0100, 1'b0);
        wait16("after_abort", 4, 16'hFFFF, 1'b1, 1'b0, 1'b0);

        // Exhaustive 4-bit sweep: DIGIT=4 completes after 1 edge, DIGIT=1 after 4.
        prev41 = '0;
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp4   = model4(av, bv, ci);
                    a4     = av[3:0];
                    b4     = bv[3:0];
                    bin4   = ci[0];
                    start4 = 1'b1;
                    @(posedge clk);
                    #1;
                    start4 = 1'b0;
                    a4     = ~a4;
                    b4     = ~b4;
                    for (int k = 1; k <= 4; k++) begin
                        @(posedge clk);
                        #1;
                        chk($sformatf("w4d4_%0d_%0d_%0d_k%0d", av, bv, ci, k),
                            {23'd0, busy44, done44, d44, bo44, ov44, zero44},
                            {23'd0, 1'b0, (k == 1), exp4});
                        if (k < 4) begin
                            chk($sformatf("w4d1_%0d_%0d_%0d_k%0d", av, bv, ci, k),
                                {23'd0, busy41, done41, d41, bo41, ov41, zero41},
                                {23'd0, 2'b10, prev41});
                        end else begin
                            chk($sformatf("w4d1_%0d_%0d_%0d_done", av, bv, ci),
                                {23'd0, busy41, done41, d41, bo41, ov41, zero41},
                                {23'd0, 2'b01, exp4});
                        end
                    end
                    prev41 = exp4;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
